// File: rtl/regpipe_arstn.sv
// regpipe_arstn: valid/ready register pipeline with bubble collapsing, clock enable, flush and async reset
module regpipe_arstn #(
  parameter int width = 16,
  parameter int depth = 3,
  parameter logic [width-1:0] init = '0
) (
  input  logic                           CLK,
  input  logic                           ASYNCRESETN,
  input  logic                           CE,
  input  logic                           flush,
  input  logic [width-1:0]               in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [width-1:0]               out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(depth+1)-1:0]     count
);
  localparam int cw = $clog2(depth + 1);
  logic [width-1:0] data [depth];
  logic [width-1:0] din [depth];
  logic [depth-1:0] valid, vin, valid_n, advance;
  logic [cw-1:0] count_n;
  logic take_out, acc;
  assign out_valid = CE & ~flush & valid[depth-1];
  assign take_out = out_valid & out_ready;
  assign out_data = data[depth-1];
  // in_ready is masked during reset because empty stages would otherwise advertise space
  assign in_ready = CE & ~flush & ASYNCRESETN & advance[0];
  always_comb begin
    acc = take_out;
    advance = '0;
    valid_n = '0;
    count_n = '0;
    for (int i = depth - 1; i >= 0; i--) begin
      acc = acc | ~valid[i];
      advance[i] = acc;
    end
    for (int i = 0; i < depth; i++) begin
      din[i] = i == 0 ? in_data : data[(i == 0) ? 0 : i - 1];
      vin[i] = i == 0 ? in_valid : valid[(i == 0) ? 0 : i - 1];
      valid_n[i] = advance[i] ? vin[i] : valid[i];
      count_n = count_n + cw'(valid_n[i]);
    end
  end
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN || flush) begin
      valid <= '0;
      count <= '0;
      for (int i = 0; i < depth; i++) data[i] <= init;
    end else if (CE) begin
      valid <= valid_n;
      count <= count_n;
      for (int i = 0; i < depth; i++)
        if (advance[i] && vin[i]) data[i] <= din[i];
    end
  end
endmodule

// File: tb/tb_regpipe_arstn.sv
// tb_regpipe_arstn: directed checks of streaming, backpressure, bubbles, CE stall, flush and async reset
module tb_regpipe_arstn;
  logic CLK = 0, ASYNCRESETN = 0, CE = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic [15:0] in_data = '0, out_data;
  logic in_ready, out_valid;
  logic [1:0] count;
  int n_cmp = 0, n_err = 0;

  regpipe_arstn #(.width(16), .depth(3), .init(16'h0000)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .CE(CE), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drv(input logic ce, input logic fl, input logic iv, input logic [15:0] d, input logic ordy);
    CE = ce; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
  endtask

  task automatic st(input string tag, input logic ov, input logic [15:0] od, input logic [1:0] c, input logic ir);
    chk({tag, "_ov"}, 32'(out_valid), 32'(ov));
    if (ov) chk({tag, "_od"}, 32'(out_data), 32'(od));
    chk({tag, "_cnt"}, 32'(count), 32'(c));
    chk({tag, "_ir"}, 32'(in_ready), 32'(ir));
  endtask

  initial begin
    #2;
    st("rst", 0, 0, 0, 0);
    chk("rst_od", 32'(out_data), 0);
    #1 ASYNCRESETN = 1;
    tick();
    // streaming
    drv(1, 0, 1, 16'h0001, 1); st("s0", 0, 0, 0, 1); tick();
    drv(1, 0, 1, 16'h0002, 1); st("s1", 0, 0, 1, 1); tick();
    drv(1, 0, 1, 16'h0003, 1); st("s2", 0, 0, 2, 1); tick();
    drv(1, 0, 0, 16'h0000, 1); st("s3", 1, 16'h0001, 3, 1); tick();
    st("s4", 1, 16'h0002, 2, 1); tick();
    st("s5", 1, 16'h0003, 1, 1); tick();
    st("s6", 0, 0, 0, 1);
    // backpressure
    drv(1, 0, 1, 16'h0010, 0); st("b0", 0, 0, 0, 1); tick();
    drv(1, 0, 1, 16'h0011, 0); st("b1", 0, 0, 1, 1); tick();
    drv(1, 0, 1, 16'h0012, 0); st("b2", 0, 0, 2, 1); tick();
    drv(1, 0, 1, 16'h0013, 0); st("b3", 1, 16'h0010, 3, 0); tick();
    st("b4", 1, 16'h0010, 3, 0);
    drv(1, 0, 1, 16'h0013, 1); st("b5", 1, 16'h0010, 3, 1); tick();
    drv(1, 0, 1, 16'h0014, 1); st("b6", 1, 16'h0011, 3, 1); tick();
    drv(1, 0, 0, 16'h0000, 1); st("b7", 1, 16'h0012, 3, 1); tick();
    st("b8", 1, 16'h0013, 2, 1); tick();
    st("b9", 1, 16'h0014, 1, 1); tick();
    st("b10", 0, 0, 0, 1);
    // bubble collapse
    drv(1, 0, 1, 16'hABCD, 0); tick();
    drv(1, 0, 0, 16'h0000, 0); st("c0", 0, 0, 1, 1); tick();
    st("c1", 0, 0, 1, 1); tick();
    st("c2", 1, 16'hABCD, 1, 1);
    drv(1, 0, 1, 16'h1111, 0); tick();
    drv(1, 0, 1, 16'h2222, 0); st("c3", 1, 16'hABCD, 2, 1); tick();
    drv(1, 0, 0, 16'h0000, 0); st("c4", 1, 16'hABCD, 3, 0);
    drv(1, 0, 0, 16'h0000, 1); tick();
    st("c5", 1, 16'h1111, 2, 1); tick();
    st("c6", 1, 16'h2222, 1, 1); tick();
    st("c7", 0, 0, 0, 1);
    // CE stall
    drv(1, 0, 1, 16'h0021, 1); tick();
    drv(1, 0, 1, 16'h0022, 1); tick();
    drv(0, 0, 1, 16'h0023, 1); st("e0", 0, 0, 2, 0);
    for (int k = 0; k < 4; k++) tick();
    st("e1", 0, 0, 2, 0);
    drv(1, 0, 1, 16'h0023, 1); st("e2", 0, 0, 2, 1); tick();
    drv(1, 0, 0, 16'h0000, 1); st("e3", 1, 16'h0021, 3, 1); tick();
    st("e4", 1, 16'h0022, 2, 1); tick();
    st("e5", 1, 16'h0023, 1, 1); tick();
    st("e6", 0, 0, 0, 1);
    // flush
    drv(1, 0, 1, 16'h0031, 0); tick();
    drv(1, 0, 1, 16'h0032, 0); tick();
    drv(1, 0, 1, 16'h0033, 0); tick();
    drv(1, 1, 1, 16'h0034, 0); st("f0", 0, 0, 3, 0); tick();
    drv(1, 0, 0, 16'h0000, 1); st("f1", 0, 0, 0, 1);
    chk("f1_od", 32'(out_data), 0);
    for (int k = 0; k < 3; k++) tick();
    st("f2", 0, 0, 0, 1);
    // async reset
    drv(1, 0, 1, 16'h0041, 0); tick();
    drv(1, 0, 1, 16'h0042, 0); tick();
    drv(1, 0, 0, 16'h0000, 0); st("r0", 0, 0, 2, 1);
    #2 ASYNCRESETN = 0;
    #1 st("r1", 0, 0, 0, 0);
    chk("r1_od", 32'(out_data), 0);
    #1 ASYNCRESETN = 1;
    tick();
    drv(1, 0, 1, 16'h0051, 1); st("r2", 0, 0, 0, 1); tick();
    drv(1, 0, 0, 16'h0000, 1); tick(); tick();
    st("r3", 1, 16'h0051, 1, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
